// File: rtl/cpu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_pkg : types and constants shared by the fetch stage and its queue     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry FIFO of fetched {instr, pc} with flush          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head_entry,
  output logic [PTR_W:0]     count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fetch_stage : owns the fetch PC, issues imem requests, queues responses   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        takeBranch,
  input  logic [31:0] branch_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_PC,
  output logic [31:0] if_PC_plus4,
  input  logic        if_ready
);

  localparam int unsigned CNT_W         = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_STEP       = 32'(INSTR_BYTES);
  localparam logic [31:0] PC_ALIGN_MASK = ~(PC_STEP - 32'd1);
  localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         outstanding_q, outstanding_d;
  logic         drop_q, drop_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_next;
  logic         push, pop, grant;
  fetch_entry_t push_entry, head_entry;

  assign if_valid   = ~rst & ~takeBranch & (count != '0);
  assign pop        = if_valid & if_ready;
  assign push       = imem_rvalid & outstanding_q & ~drop_q & ~takeBranch;
  assign count_next = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};

  // Single outstanding request; the slot frees in the same cycle its response lands.
  assign imem_req   = ~rst & ~takeBranch & (~outstanding_q | imem_rvalid)
                    & (count_next < (CNT_W+1)'(DEPTH));
  assign grant      = imem_req & imem_gnt;
  assign imem_addr  = rst ? RESET_PC_AL : fetch_pc_q;

  assign push_entry = '{instr: imem_rdata, pc: out_pc_q};

  fetch_queue #(
    .DEPTH      (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (takeBranch),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign if_instr    = rst ? '0 : head_entry.instr;
  assign if_PC       = rst ? '0 : head_entry.pc;
  assign if_PC_plus4 = if_PC + PC_STEP;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    out_pc_d      = out_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (takeBranch) begin
      fetch_pc_d = branch_PC & PC_ALIGN_MASK;
      // A response still in flight belongs to the old path and must be swallowed.
      if (outstanding_q) begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          drop_d        = 1'b0;
        end else begin
          drop_d        = 1'b1;
        end
      end
    end else begin
      if (outstanding_q && imem_rvalid) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
      if (grant) begin
        outstanding_d = 1'b1;
        out_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC_AL;
      out_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      out_pc_q      <= out_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_fetch_stage : self-checking bench for fetch_stage                      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, takeBranch, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] branch_PC, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_PC, if_PC_plus4;

  int compared   = 0;
  int mismatched = 0;

  // Reference: delivered entries, the single expected in-flight fetch and an epoch
  // that invalidates fetches issued before the latest redirect or reset.
  logic [63:0] model_q[$];
  logic        model_out   = 1'b0;
  logic [31:0] exp_fetch   = RESET_PC;
  int          cur_epoch   = 0;
  int          lat         = 1;
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr    = '0;
  logic [31:0] mem_pc      = '0;
  int          mem_epoch   = 0;
  int          mem_wait    = 0;
  logic [31:0] rv_pc       = '0;
  int          rv_epoch    = -1;

  fetch_stage #(
    .RESET_PC    (RESET_PC),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .takeBranch  (takeBranch),
    .branch_PC   (branch_PC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_PC       (if_PC),
    .if_PC_plus4 (if_PC_plus4),
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction memory: one response per grant, returned lat cycles later.
  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_pending) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(mem_addr);
        rv_pc       = mem_pc;
        rv_epoch    = mem_epoch;
        mem_pending = 1'b0;
      end
    end
  end

  // Per-cycle compare against the reference, then advance it past the coming edge.
  always @(negedge clk) begin
    int          occ;
    bit          exp_valid, push_m, pop_m, exp_req, grant_now;
    logic [63:0] head;
    occ       = model_q.size();
    exp_valid = !rst && !takeBranch && occ != 0;
    chk_bit("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      head = model_q[0];
      chk("if_PC", if_PC, head[31:0]);
      chk("if_instr", if_instr, head[63:32]);
      chk("if_PC_plus4", if_PC_plus4, head[31:0] + 32'd4);
    end
    if (rst) begin
      chk("rst_if_PC", if_PC, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
    end
    push_m  = imem_rvalid && model_out && rv_epoch == cur_epoch && !takeBranch && !rst;
    pop_m   = exp_valid && if_ready;
    exp_req = !rst && !takeBranch && (!model_out || imem_rvalid)
              && (occ + int'(push_m) - int'(pop_m) < int'(DEPTH));
    chk_bit("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
    grant_now = imem_req && imem_gnt;

    if (rst) begin
      model_q.delete();
      model_out = 1'b0;
      exp_fetch = RESET_PC;
      cur_epoch++;
    end else if (takeBranch) begin
      model_q.delete();
      exp_fetch = {branch_PC[31:2], 2'b00};
      cur_epoch++;
      if (imem_rvalid) model_out = 1'b0;
    end else begin
      if (pop_m) void'(model_q.pop_front());
      if (push_m) model_q.push_back({memf(rv_pc), rv_pc});
      if (imem_rvalid) model_out = 1'b0;
      if (grant_now) begin
        chk_bit("one_outstanding", mem_pending, 1'b0);
        model_out   = 1'b1;
        mem_pending = 1'b1;
        mem_addr    = imem_addr;
        mem_pc      = exp_fetch;
        mem_epoch   = cur_epoch;
        mem_wait    = lat;
        exp_fetch   = exp_fetch + 32'd4;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_grant(input logic [31:0] a, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && imem_addr == a) found = 1'b1;
    end
    chk_bit("wait_grant", found, 1'b1);
  endtask

  task automatic wait_valid(input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (if_valid) found = 1'b1;
    end
    chk_bit("wait_valid", found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; takeBranch = 1'b0; branch_PC = '0; imem_gnt = 1'b1;
    if_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

    // Streaming from reset with a 1-cycle memory.
    repeat (3) next_cycle();
    rst = 1'b0;
    mid(); chk_bit("r0_req", imem_req, 1'b1); chk("r0_addr", imem_addr, 32'h0);
    chk_bit("r0_valid", if_valid, 1'b0);
    next_cycle(); mid(); chk("r1_addr", imem_addr, 32'h4);
    next_cycle(); mid(); chk("r2_addr", imem_addr, 32'h8);
    chk_bit("r2_valid", if_valid, 1'b1); chk("r2_pc", if_PC, 32'h0);
    chk("r2_pc4", if_PC_plus4, 32'h4);
    repeat (5) next_cycle();

    // Back-pressure fills the queue and stalls fetch.
    rst = 1'b1; if_ready = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    repeat (4) next_cycle();
    mid(); chk("full_pc", if_PC, 32'h0); chk_bit("full_req", imem_req, 1'b0);
    chk("full_addr", imem_addr, 32'h8);
    repeat (2) next_cycle();
    if_ready = 1'b1;
    mid(); chk("drain0", if_PC, 32'h0);
    next_cycle(); mid(); chk("drain1", if_PC, 32'h4);
    next_cycle(); mid(); chk("drain2", if_PC, 32'h8);

    // Redirect while a slow fetch of 0x10 is in flight.
    next_cycle();
    rst = 1'b1; lat = 4;
    repeat (2) next_cycle();
    rst = 1'b0;
    wait_grant(32'h10, 40);
    next_cycle(); takeBranch = 1'b1; branch_PC = 32'h200;
    mid(); chk_bit("br_valid", if_valid, 1'b0); chk_bit("br_req", imem_req, 1'b0);
    next_cycle(); takeBranch = 1'b0; lat = 1;
    wait_valid(40);
    chk("br_target", if_PC, 32'h200);

    // Redirect coincident with a response, unaligned target.
    wait_grant(32'h20C, 20);
    next_cycle(); takeBranch = 1'b1; branch_PC = 32'h3;
    mid(); chk_bit("brv_valid", if_valid, 1'b0);
    next_cycle(); takeBranch = 1'b0;
    mid(); chk_bit("brv_req", imem_req, 1'b1); chk("brv_addr", imem_addr, 32'h0);
    repeat (2) next_cycle();
    mid(); chk_bit("brv_valid2", if_valid, 1'b1); chk("brv_pc", if_PC, 32'h0);

    // Fetch address wraps past the top of the address space.
    next_cycle(); takeBranch = 1'b1; branch_PC = 32'hFFFF_FFF8;
    next_cycle(); takeBranch = 1'b0;
    repeat (2) next_cycle();
    mid(); chk("wrap_addr", imem_addr, 32'h0);
    next_cycle();
    mid(); chk("wrap_pc", if_PC, 32'hFFFF_FFFC); chk("wrap_pc4", if_PC_plus4, 32'h0);

    // Reset with a queued entry and a request in flight; the late response is ignored.
    next_cycle(); if_ready = 1'b0; lat = 4; takeBranch = 1'b1; branch_PC = 32'h40;
    next_cycle(); takeBranch = 1'b0;
    wait_grant(32'h44, 20);
    next_cycle(); rst = 1'b1; imem_gnt = 1'b0;
    mid(); chk_bit("rst_valid", if_valid, 1'b0); chk_bit("rst_req", imem_req, 1'b0);
    next_cycle(); rst = 1'b0;
    mid(); chk_bit("post_rst_valid", if_valid, 1'b0); chk("post_rst_addr", imem_addr, RESET_PC);
    repeat (4) next_cycle();
    mid(); chk_bit("late_rvalid_valid", if_valid, 1'b0);
    next_cycle(); imem_gnt = 1'b1; lat = 1; if_ready = 1'b1;
    wait_valid(20);
    chk("post_rst_pc", if_PC, RESET_PC);
    chk("post_rst_instr", if_instr, 32'h1357_6420);
    repeat (5) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
